mips_branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline; successor to the fixed delayed-branch scheme.
- IF stage looks up a direct-mapped branch target buffer (BTB) with saturating counters per entry, and gets a predicted next PC in the same cycle.
- The resolving stage (EXE) sends the branch outcome back; the block updates the table and flags mispredicts so the controller can flush and redirect.
- Static mode (DYNAMIC=0) always predicts not-taken but still detects mispredicts.

---
 rtl/mips_branch_predictor_if.sv | 35 +++
 rtl/mips_branch_predictor.sv | 112 +++++++++++
 tb/tb_mips_branch_predictor.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_branch_predictor_if.sv
// Fetch-lookup, branch-resolve and statistics signals of the MIPS branch predictor.
// The predictor is the slave and the pipeline controller is the master.
interface mips_branch_predictor_if #(
  parameter int STAT_WIDTH = 16
);
  logic                  if_en;
  logic [31:0]           if_pc;
  logic                  pred_taken;
  logic [31:0]           pred_target;
  logic                  upd_valid;
  logic [31:0]           upd_pc;
  logic                  upd_taken;
  logic [31:0]           upd_target;
  logic                  upd_pred_taken;
  logic [31:0]           upd_pred_target;
  logic                  clear;
  logic                  mispredict;
  logic [31:0]           redirect_pc;
  logic [STAT_WIDTH-1:0] lookup_cnt;
  logic [STAT_WIDTH-1:0] mispredict_cnt;

  modport master (
    output if_en, if_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           lookup_cnt, mispredict_cnt
  );

  modport slave (
    input  if_en, if_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear,
    output pred_taken, pred_target, mispredict, redirect_pc,
           lookup_cnt, mispredict_cnt
  );
endinterface

// File: rtl/mips_branch_predictor.sv
// Direct-mapped BTB with saturating counters: zero-latency IF lookup, EXE-stage
// update, mispredict/redirect generation and saturating statistics.
module mips_branch_predictor #(
  parameter int ENTRIES    = 16,
  parameter int TAG_BITS   = 8,
  parameter int CNT_BITS   = 2,
  parameter int DYNAMIC    = 1,
  parameter int STAT_WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  mips_branch_predictor_if.slave bus
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam bit DYN      = (DYNAMIC != 0);

  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  logic [ENTRIES-1:0]  r_valid;
  tag_t                r_tag    [ENTRIES];
  logic [29:0]         r_target [ENTRIES];
  logic [CNT_BITS-1:0] r_cnt    [ENTRIES];

  logic [STAT_WIDTH-1:0] r_lookup_cnt;
  logic [STAT_WIDTH-1:0] r_mispredict_cnt;

  idx_t w_lk_idx;
  tag_t w_lk_tag;
  logic w_lk_hit;
  logic w_pred_taken;

  idx_t w_upd_idx;
  tag_t w_upd_tag;
  logic w_upd_hit;
  logic w_upd_en;
  logic w_mispredict;

  // Lookup reads the table as it stands before this edge's update (no bypass).
  assign w_lk_idx     = bus.if_pc[IDX_BITS+1:2];
  assign w_lk_tag     = bus.if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken = DYN && w_lk_hit && r_cnt[w_lk_idx][CNT_BITS-1];

  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_taken ? {r_target[w_lk_idx], 2'b00}
                                        : bus.if_pc + 32'd4;

  assign w_upd_idx = bus.upd_pc[IDX_BITS+1:2];
  assign w_upd_tag = bus.upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_en  = DYN && bus.upd_valid && !bus.clear;

  assign w_mispredict = bus.upd_valid &&
                        ((bus.upd_taken != bus.upd_pred_taken) ||
                         (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

  // The not-taken path resumes after the delay slot.
  assign bus.mispredict  = w_mispredict;
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd8;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the lookup-sees-old-contents rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= '0;
    end else if (bus.clear) begin
      r_valid <= '0;
    end else if (w_upd_en) begin
      if (w_upd_hit) begin
        if (bus.upd_taken) begin
          if (r_cnt[w_upd_idx] != CNT_MAX) r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + CNT_BITS'(1);
        end else begin
          if (r_cnt[w_upd_idx] != '0) r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - CNT_BITS'(1);
        end
      end else if (bus.upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_cnt[w_upd_idx]   <= CNT_WEAK;
      end
    end
  end

  // NOTE: tag and target storage has no reset; an entry's payload is only
  // observed through its valid bit, which is reset, so plain RAM suffices.
  always_ff @(posedge clk) begin
    if (!rst && w_upd_en && bus.upd_taken) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= bus.upd_target[31:2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lookup_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (bus.if_en && (r_lookup_cnt != '1))
        r_lookup_cnt <= r_lookup_cnt + STAT_WIDTH'(1);
      if (w_mispredict && (r_mispredict_cnt != '1))
        r_mispredict_cnt <= r_mispredict_cnt + STAT_WIDTH'(1);
    end
  end

  assign bus.lookup_cnt     = r_lookup_cnt;
  assign bus.mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Bench for mips_branch_predictor: directed scenarios plus randomized traffic
// against a table-level reference model; a static, narrow-statistics instance too.
module tb_mips_branch_predictor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_branch_predictor_if #(.STAT_WIDTH(16)) bus_d ();
  mips_branch_predictor_if #(.STAT_WIDTH(4))  bus_s ();

  mips_branch_predictor #(
    .ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .DYNAMIC(1), .STAT_WIDTH(16)
  ) u_dyn (
    .clk(clk), .rst(rst), .bus(bus_d.slave)
  );

  mips_branch_predictor #(
    .ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .DYNAMIC(0), .STAT_WIDTH(4)
  ) u_sta (
    .clk(clk), .rst(rst), .bus(bus_s.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one record per BTB slot, counters kept as plain integers.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  int unsigned m_lookups;
  int unsigned m_mispreds;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hF);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'((pc >> 6) & 32'hFF);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_lookups  = 0;
    m_mispreds = 0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output bit taken,
                                        output logic [31:0] tgt);
    int s;
    s     = slot_of(pc);
    taken = m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_ctr[s] >= 2);
    tgt   = taken ? m_target[s] : pc + 32'd4;
  endfunction

  task automatic peek(input logic [31:0] pc);
    bus_d.if_pc     = pc;
    bus_d.if_en     = 1'b0;
    bus_d.upd_valid = 1'b0;
    bus_d.clear     = 1'b0;
    #1;
  endtask

  // One cycle on the dynamic instance: check combinational outputs, advance the
  // model across the edge, clock, then check the statistics.
  task automatic drive_d(input bit en, input logic [31:0] pc,
                         input bit uv, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input bit upt,
                         input logic [31:0] uptgt, input bit clr);
    bit          e_taken, e_mis, hit;
    logic [31:0] e_tgt, e_redir;
    int          s;
    bus_d.if_en = en;  bus_d.if_pc = pc;
    bus_d.upd_valid = uv; bus_d.upd_pc = upc; bus_d.upd_taken = ut;
    bus_d.upd_target = utgt; bus_d.upd_pred_taken = upt;
    bus_d.upd_pred_target = uptgt; bus_d.clear = clr;
    #1;
    model_predict(pc, e_taken, e_tgt);
    e_mis   = uv && ((ut != upt) || (ut && (utgt != uptgt)));
    e_redir = ut ? utgt : upc + 32'd8;
    check("pred_taken",  bus_d.pred_taken,  e_taken);
    check("pred_target", bus_d.pred_target, e_tgt);
    check("mispredict",  bus_d.mispredict,  e_mis);
    check("redirect_pc", bus_d.redirect_pc, e_redir);
    if (clr) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      s   = slot_of(upc);
      hit = m_valid[s] && (m_tag[s] == tag_of(upc));
      if (hit && ut) begin
        m_ctr[s]    = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
        m_target[s] = utgt & ~32'h3;
      end else if (hit) begin
        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
      end else if (ut) begin
        m_valid[s]  = 1'b1;
        m_tag[s]    = tag_of(upc);
        m_target[s] = utgt & ~32'h3;
        m_ctr[s]    = 2;
      end
    end
    if (en && m_lookups < 65535) m_lookups++;
    if (e_mis && m_mispreds < 65535) m_mispreds++;
    @(posedge clk);
    #1;
    check("lookup_cnt",     bus_d.lookup_cnt,     m_lookups);
    check("mispredict_cnt", bus_d.mispredict_cnt, m_mispreds);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_C000;
    return pc;
  endfunction

  initial begin
    bit          pt, ut, upt;
    logic [31:0] ptg, upc, utgt, uptgt;
    int          s_exp;

    bus_d.if_en = 0; bus_d.if_pc = 0; bus_d.upd_valid = 0; bus_d.upd_pc = 0;
    bus_d.upd_taken = 0; bus_d.upd_target = 0; bus_d.upd_pred_taken = 0;
    bus_d.upd_pred_target = 0; bus_d.clear = 0;
    bus_s.if_en = 0; bus_s.if_pc = 0; bus_s.upd_valid = 0; bus_s.upd_pc = 0;
    bus_s.upd_taken = 0; bus_s.upd_target = 0; bus_s.upd_pred_taken = 0;
    bus_s.upd_pred_target = 0; bus_s.clear = 0;
    model_reset();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_lookup_cnt", bus_d.lookup_cnt, 32'd0);
    check("rst_mispredict_cnt", bus_d.mispredict_cnt, 32'd0);
    peek(32'h40);
    check("rst_pred_taken", bus_d.pred_taken, 32'd0);
    check("rst_pred_target", bus_d.pred_target, 32'h44);

    // Plain lookup, then first taken branch allocating the entry.
    drive_d(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    check("t1_lookup_cnt", bus_d.lookup_cnt, 32'd1);
    drive_d(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
    check("t2_mispredict_cnt", bus_d.mispredict_cnt, 32'd1);
    peek(32'h40);
    check("t2_pred_taken", bus_d.pred_taken, 32'd1);
    check("t2_pred_target", bus_d.pred_target, 32'h100);

    // Counter walk 10 -> 11 -> 11 -> 10 -> 01.
    drive_d(0, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0);
    drive_d(0, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0);
    drive_d(0, 32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 0);
    peek(32'h40);
    check("t3_weak_taken", bus_d.pred_target, 32'h100);
    drive_d(0, 32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 0);
    peek(32'h40);
    check("t3_weak_nt_taken", bus_d.pred_taken, 32'd0);
    check("t3_weak_nt_target", bus_d.pred_target, 32'h44);

    // Alias at the same index with a different tag.
    peek(32'h440);
    check("t4_alias_miss", bus_d.pred_target, 32'h444);
    drive_d(0, 32'h440, 1, 32'h440, 1, 32'h200, 0, 32'h444, 0);
    peek(32'h440);
    check("t4_alias_hit", bus_d.pred_target, 32'h200);
    peek(32'h40);
    check("t4_evicted", bus_d.pred_target, 32'h44);

    // clear beats a simultaneous taken update.
    drive_d(0, 32'h0, 1, 32'h80, 1, 32'h300, 0, 32'h84, 1);
    peek(32'h80);
    check("t5_clear_80", bus_d.pred_target, 32'h84);
    peek(32'h440);
    check("t5_clear_440", bus_d.pred_target, 32'h444);
    check("t5_lookup_kept", bus_d.lookup_cnt, 32'd1);

    // Same-cycle lookup and update of one index sees the old target.
    drive_d(0, 32'h0, 1, 32'h80, 1, 32'h300, 0, 32'h84, 0);
    drive_d(1, 32'h80, 1, 32'h80, 1, 32'h380, 1, 32'h300, 0);
    peek(32'h80);
    check("t5_new_target", bus_d.pred_target, 32'h380);

    // Randomized traffic with one mid-run asynchronous reset.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_lookup_cnt", bus_d.lookup_cnt, 32'd0);
        check("mid_rst_mispredict_cnt", bus_d.mispredict_cnt, 32'd0);
        #1 rst = 1'b0;
      end
      upc  = rnd_pc();
      ut   = 1'($urandom_range(0, 1));
      utgt = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        model_predict(upc, upt, uptgt);
      end else begin
        upt   = 1'($urandom_range(0, 1));
        uptgt = ($urandom_range(0, 1) == 1) ? utgt : $urandom;
      end
      drive_d(1'($urandom_range(0, 1)), rnd_pc(), 1'($urandom_range(0, 3) != 0),
              upc, ut, utgt, upt, uptgt, $urandom_range(0, 63) == 0);
    end

    // Static instance: never predicts taken, 4-bit statistics saturate at 15.
    s_exp = 0;
    for (int n = 0; n < 20; n++) begin
      bus_s.if_en = 1; bus_s.if_pc = 32'h40; bus_s.upd_valid = 1;
      bus_s.upd_pc = 32'h40; bus_s.upd_taken = 1; bus_s.upd_target = 32'h100;
      bus_s.upd_pred_taken = 0; bus_s.upd_pred_target = 32'h44;
      #1;
      check("sta_pred_taken", bus_s.pred_taken, 32'd0);
      check("sta_pred_target", bus_s.pred_target, 32'h44);
      check("sta_mispredict", bus_s.mispredict, 32'd1);
      check("sta_redirect_pc", bus_s.redirect_pc, 32'h100);
      if (s_exp < 15) s_exp++;
      @(posedge clk);
      #1;
      check("sta_mispredict_cnt", bus_s.mispredict_cnt, s_exp);
    end
    check("sta_lookup_sat", bus_s.lookup_cnt, 32'd15);
    bus_s.upd_pred_taken = 1; bus_s.upd_pred_target = 32'h100;
    #1;
    check("sta_correct_pred", bus_s.mispredict, 32'd0);
    bus_s.upd_valid = 0; bus_s.if_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
